// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment receive-side monitor.
//   - segment encodings {g,f,e,d,c,b,a} for digits 0..9 plus blank
//   - seg_decode(): maps a segment pattern to {valid, blank, digit}
//   - mon_state_t: digit-tracking state of the monitor
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7C;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       valid;  // pattern is one of the ten digits
    logic       blank;  // all segments off
    logic [3:0] digit;
  } seg_dec_t;

  typedef enum logic [1:0] {
    NO_DIGIT = 2'd0,
    FIRST    = 2'd1,
    TRACK    = 2'd2
  } mon_state_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t d;
    d = '0;
    case (seg)
      SEG_0:     begin d.valid = 1'b1; d.digit = 4'd0; end
      SEG_1:     begin d.valid = 1'b1; d.digit = 4'd1; end
      SEG_2:     begin d.valid = 1'b1; d.digit = 4'd2; end
      SEG_3:     begin d.valid = 1'b1; d.digit = 4'd3; end
      SEG_4:     begin d.valid = 1'b1; d.digit = 4'd4; end
      SEG_5:     begin d.valid = 1'b1; d.digit = 4'd5; end
      SEG_6:     begin d.valid = 1'b1; d.digit = 4'd6; end
      SEG_7:     begin d.valid = 1'b1; d.digit = 4'd7; end
      SEG_8:     begin d.valid = 1'b1; d.digit = 4'd8; end
      SEG_9:     begin d.valid = 1'b1; d.digit = 4'd9; end
      SEG_BLANK: d.blank = 1'b1;
      default:   ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_monitor_if.sv
// seg7_monitor_if: segment bus, controls and monitor results.
//   master: drives seg_in/ena/clr_err, observes results
//   slave : the monitor itself
interface seg7_monitor_if #(
  parameter int unsigned CNT_WIDTH = 24
);
  logic                 ena;
  logic [6:0]           seg_in;
  logic                 clr_err;
  logic [3:0]           digit_out;
  logic                 digit_valid;
  logic                 digit_strobe;
  logic [CNT_WIDTH-1:0] period_out;
  logic                 period_valid;
  logic                 seq_err;
  logic                 invalid_err;
  logic [7:0]           err_count;

  modport master (
    output ena, seg_in, clr_err,
    input  digit_out, digit_valid, digit_strobe, period_out, period_valid,
           seq_err, invalid_err, err_count
  );

  modport slave (
    input  ena, seg_in, clr_err,
    output digit_out, digit_valid, digit_strobe, period_out, period_valid,
           seq_err, invalid_err, err_count
  );
endinterface

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter: registers the segment bus and accepts a pattern once it
// has been sampled STABLE_CYCLES times in a row.
//   clk, reset : clock, synchronous active-high reset
//   ena        : gates accept only; sampling and run counting always continue
//   seg_in     : raw segment bus
//   accept     : single-cycle event, pattern valid alongside it
//   pattern    : current candidate pattern
module seg7_stable_filter #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [6:0] seg_in,
  output logic       accept,
  output logic [6:0] pattern
);

  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

  logic [6:0] seg_q;
  logic [6:0] cand_q;
  logic [3:0] run_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q  <= '0;
      cand_q <= '0;
      run_q  <= '0;
    end else begin
      seg_q <= seg_in;
      if (seg_q == cand_q) begin
        if (run_q != RUN_MAX) run_q <= run_q + 4'd1;
      end else begin
        cand_q <= seg_q;
        run_q  <= 4'd1;
      end
    end
  end

  // Fires while the counter is about to step into RUN_MAX, so the accept
  // is consumed on the same edge the run completes.
  assign accept  = ena && (seg_q == cand_q) && (run_q == RUN_MAX - 4'd1);
  assign pattern = cand_q;

endmodule

// File: rtl/seg7_monitor.sv
// seg7_monitor: receive-side checker for the seven-segment seconds display.
// Filters and decodes the segment bus, checks the 0..9 wrap sequence,
// measures cycles between digit changes and counts errors.
//   clk, reset : clock, synchronous active-high reset
//   bus        : seg7_monitor_if slave (seg_in/ena/clr_err in, results out)
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 24
) (
  input  logic           clk,
  input  logic           reset,
  seg7_monitor_if.slave  bus
);

  logic       accept;
  logic [6:0] pattern;
  seg_dec_t   dec;

  seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk     (clk),
    .reset   (reset),
    .ena     (bus.ena),
    .seg_in  (bus.seg_in),
    .accept  (accept),
    .pattern (pattern)
  );

  assign dec = seg_decode(pattern);

  mon_state_t           state_q, state_d;
  logic [3:0]           digit_q;
  logic                 strobe_q, seq_q, inv_q;
  logic [CNT_WIDTH-1:0] period_cnt_q, period_q;
  logic [7:0]           err_q;

  logic       dv;
  logic       strobe_ev, seq_ev, inv_ev;
  logic [3:0] next_digit;

  assign dv = (state_q != NO_DIGIT);

  always_comb begin
    strobe_ev  = 1'b0;
    seq_ev     = 1'b0;
    inv_ev     = 1'b0;
    state_d    = state_q;
    next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

    // Priority: blank, invalid, repeat of current digit, new digit.
    if (accept) begin
      if (dec.blank) begin
      end else if (!dec.valid) begin
        inv_ev = 1'b1;
      end else if (dv && (dec.digit == digit_q)) begin
      end else begin
        strobe_ev = 1'b1;
        seq_ev    = dv && (dec.digit != next_digit);
      end
    end

    unique case (state_q)
      NO_DIGIT: if (strobe_ev) state_d = FIRST;
      FIRST:    if (strobe_ev) state_d = TRACK;
      TRACK:    state_d = TRACK;
      default:  state_d = NO_DIGIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NO_DIGIT;
      digit_q      <= '0;
      strobe_q     <= 1'b0;
      seq_q        <= 1'b0;
      inv_q        <= 1'b0;
      period_cnt_q <= '0;
      period_q     <= '0;
      err_q        <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_ev;
      seq_q    <= seq_ev;
      inv_q    <= inv_ev;
      if (strobe_ev) digit_q <= dec.digit;

      // The strobe edge counts as 1, so the captured value is t2-t1.
      if (strobe_ev) begin
        period_cnt_q <= CNT_WIDTH'(1);
      end else if (bus.ena && (period_cnt_q != '1)) begin
        period_cnt_q <= period_cnt_q + CNT_WIDTH'(1);
      end
      if (strobe_ev && dv) period_q <= period_cnt_q;

      if (bus.clr_err) begin
        err_q <= '0;
      end else if ((seq_ev || inv_ev) && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign bus.digit_out    = digit_q;
  assign bus.digit_valid  = dv;
  assign bus.digit_strobe = strobe_q;
  assign bus.period_out   = period_q;
  assign bus.period_valid = (state_q == TRACK);
  assign bus.seq_err      = seq_q;
  assign bus.invalid_err  = inv_q;
  assign bus.err_count    = err_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// tb_seg7_monitor: two monitors (24-bit and 4-bit period counters) driven with
// identical stimulus; a reference model pushes expected events into per-DUT
// queues that independent monitor processes pop and compare.
module tb_seg7_monitor;

  localparam int unsigned SC = 4;

  logic clk;
  logic reset;

  seg7_monitor_if #(.CNT_WIDTH(24)) bus_a ();
  seg7_monitor_if #(.CNT_WIDTH(4))  bus_b ();

  seg7_monitor #(.STABLE_CYCLES(SC), .CNT_WIDTH(24)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  seg7_monitor #(.STABLE_CYCLES(SC), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned cyc;
    logic [3:0]  digit;
    bit          strobe, seq, inv, dv, pv;
    int unsigned period;
    int unsigned err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

  logic [6:0]  hist[$];     // recent samples seen by the filter
  logic [6:0]  m_segq;
  bit          m_dv, m_pv;
  logic [3:0]  m_digit;
  int unsigned m_period, m_err, m_ena_edges, m_stamp;

  function automatic bit lookup(input logic [6:0] p, output logic [3:0] d);
    d = 4'd0;
    for (int i = 0; i < 10; i++)
      if (seg_tab[i] == p) begin d = 4'(i); return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_edge(input logic [6:0] s, input bit e, input bit c, input bit r);
    bit acc, strobe, seq, inv;
    logic [6:0] p;
    logic [3:0] d;
    exp_t ev;
    int n;
    if (r) begin
      hist.delete();
      m_segq = '0; m_dv = 0; m_pv = 0; m_digit = '0;
      m_period = 0; m_err = 0; m_ena_edges = 0; m_stamp = 0;
      return;
    end
    hist.push_back(m_segq);
    if (hist.size() > SC + 1) void'(hist.pop_front());
    n = hist.size();
    // accept when the newest SC samples agree and the run has just reached SC
    acc = 0;
    if (n >= SC) begin
      acc = 1;
      for (int i = 1; i <= SC; i++)
        if (hist[n-i] != hist[n-1]) acc = 0;
      if (n > SC && hist[n-SC-1] == hist[n-1]) acc = 0;
    end
    if (e) m_ena_edges++;
    strobe = 0; seq = 0; inv = 0;
    if (acc && e) begin
      p = hist[n-1];
      if (p == 7'h00) begin
      end else if (!lookup(p, d)) begin
        inv = 1;
      end else if (m_dv && d == m_digit) begin
      end else begin
        strobe = 1;
        seq = m_dv && (int'(d) != (int'(m_digit) + 1) % 10);
        if (m_dv) begin
          m_period = m_ena_edges - m_stamp;
          m_pv = 1;
        end
        m_stamp = m_ena_edges;
        m_dv = 1;
        m_digit = d;
      end
    end
    if (c) m_err = 0;
    else if ((inv || seq) && m_err < 255) m_err++;
    if (strobe || seq || inv) begin
      ev.cyc = cyc + 1; ev.digit = m_digit; ev.strobe = strobe; ev.seq = seq;
      ev.inv = inv; ev.dv = m_dv; ev.pv = m_pv; ev.period = m_period; ev.err = m_err;
      qa.push_back(ev);
      qb.push_back(ev);
    end
    m_segq = s;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [6:0] s, input bit e, input bit c, input bit r);
    bus_a.seg_in = s; bus_a.ena = e; bus_a.clr_err = c;
    bus_b.seg_in = s; bus_b.ena = e; bus_b.clr_err = c;
    reset = r;
    model_edge(s, e, c, r);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_digit"},  64'(bus_a.digit_out), 0);
    chk({nm, "_dv"},     64'(bus_a.digit_valid), 0);
    chk({nm, "_strobe"}, 64'(bus_a.digit_strobe), 0);
    chk({nm, "_period"}, 64'(bus_a.period_out), 0);
    chk({nm, "_pv"},     64'(bus_a.period_valid), 0);
    chk({nm, "_seq"},    64'(bus_a.seq_err), 0);
    chk({nm, "_inv"},    64'(bus_a.invalid_err), 0);
    chk({nm, "_err"},    64'(bus_a.err_count), 0);
    chk({nm, "_b_dv"},   64'(bus_b.digit_valid), 0);
    chk({nm, "_b_period"}, 64'(bus_b.period_out), 0);
  endtask

  // ---------------- scoreboard monitors ----------------
  task automatic cmp_evt(input string id, input exp_t e, input logic [3:0] d,
                         input logic ds, input logic se, input logic ie,
                         input logic dv, input logic pv, input logic [63:0] per,
                         input logic [7:0] ec, input int unsigned w);
    logic [63:0] pmax, pexp;
    pmax = (64'd1 << w) - 64'd1;
    pexp = (64'(e.period) > pmax) ? pmax : 64'(e.period);
    chk({id, "_cycle"},  64'(cyc), 64'(e.cyc));
    chk({id, "_digit"},  64'(d), 64'(e.digit));
    chk({id, "_strobe"}, 64'(ds), 64'(e.strobe));
    chk({id, "_seq"},    64'(se), 64'(e.seq));
    chk({id, "_inv"},    64'(ie), 64'(e.inv));
    chk({id, "_dv"},     64'(dv), 64'(e.dv));
    chk({id, "_pv"},     64'(pv), 64'(e.pv));
    chk({id, "_period"}, per, pexp);
    chk({id, "_errcnt"}, 64'(ec), 64'(e.err));
  endtask

  exp_t ea, eb;

  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].cyc < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL a_missed_event: got none expected event at cycle %0d (now %0d)", qa[0].cyc, cyc);
      void'(qa.pop_front());
    end
    if (bus_a.digit_strobe === 1'b1 || bus_a.seq_err === 1'b1 || bus_a.invalid_err === 1'b1) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_event: got event expected none (cycle %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        cmp_evt("a", ea, bus_a.digit_out, bus_a.digit_strobe, bus_a.seq_err,
                bus_a.invalid_err, bus_a.digit_valid, bus_a.period_valid,
                64'(bus_a.period_out), bus_a.err_count, 24);
      end
    end
  end

  always @(negedge clk) begin
    while (qb.size() > 0 && qb[0].cyc < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL b_missed_event: got none expected event at cycle %0d (now %0d)", qb[0].cyc, cyc);
      void'(qb.pop_front());
    end
    if (bus_b.digit_strobe === 1'b1 || bus_b.seq_err === 1'b1 || bus_b.invalid_err === 1'b1) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_event: got event expected none (cycle %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        cmp_evt("b", eb, bus_b.digit_out, bus_b.digit_strobe, bus_b.seq_err,
                bus_b.invalid_err, bus_b.digit_valid, bus_b.period_valid,
                64'(bus_b.period_out), bus_b.err_count, 4);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [6:0] pat;
    logic [3:0] dd;
    int r, len;
    bit e;

    for (int i = 0; i < 3; i++) step(7'h00, 1'b1, 1'b0, 1'b1);
    chk_zero("reset");

    // first digit: strobe on the 5th edge after the change
    hold(7'h3F, 4);
    chk("first_not_yet", 64'(bus_a.digit_valid), 0);
    hold(7'h3F, 6);
    chk("first_digit", 64'(bus_a.digit_out), 0);
    chk("first_dv", 64'(bus_a.digit_valid), 1);
    chk("first_pv", 64'(bus_a.period_valid), 0);

    // full count 1..9,0 with 1000-cycle spacing
    for (int k = 1; k <= 10; k++) hold(seg_tab[k % 10], 1000);
    chk("count_period_a", 64'(bus_a.period_out), 1000);
    chk("count_period_b", 64'(bus_b.period_out), 15);
    chk("count_pv", 64'(bus_a.period_valid), 1);
    chk("count_err", 64'(bus_a.err_count), 0);

    // 20-cycle spacing up to digit 4
    for (int k = 1; k <= 4; k++) hold(seg_tab[k], 20);
    chk("spacing20_a", 64'(bus_a.period_out), 20);
    chk("spacing20_b", 64'(bus_b.period_out), 15);

    // 3-sample glitch is ignored, 4-sample glitch is accepted
    hold(7'h7F, 3);
    hold(7'h66, 10);
    chk("glitch3_digit", 64'(bus_a.digit_out), 4);
    chk("glitch3_err", 64'(bus_a.err_count), 0);
    hold(7'h7F, 4);
    hold(7'h66, 1);
    chk("glitch4_digit", 64'(bus_a.digit_out), 8);
    chk("glitch4_err", 64'(bus_a.err_count), 1);
    hold(7'h66, 9);
    chk("back4_digit", 64'(bus_a.digit_out), 4);
    chk("back4_err", 64'(bus_a.err_count), 2);

    // invalid pattern, return to same digit, blank
    hold(7'h12, 10);
    chk("invalid_digit", 64'(bus_a.digit_out), 4);
    chk("invalid_err", 64'(bus_a.err_count), 3);
    hold(7'h66, 10);
    hold(7'h00, 10);
    chk("blank_digit", 64'(bus_a.digit_out), 4);
    chk("blank_err", 64'(bus_a.err_count), 3);

    // saturation of err_count
    step(7'h00, 1'b1, 1'b1, 1'b0);
    chk("clr_err", 64'(bus_a.err_count), 0);
    for (int k = 0; k < 256; k++) hold((k % 2 == 0) ? 7'h12 : 7'h13, 5);
    chk("err_sat", 64'(bus_a.err_count), 255);
    hold(7'h12, 4);
    step(7'h12, 1'b1, 1'b1, 1'b0);
    chk("clr_wins_inv", 64'(bus_a.invalid_err), 1);
    chk("clr_wins_cnt", 64'(bus_a.err_count), 0);

    // ena low across a stable change
    hold(7'h66, 10);
    for (int i = 0; i < 10; i++) step(7'h06, 1'b0, 1'b0, 1'b0);
    chk("ena_low_digit", 64'(bus_a.digit_out), 4);
    hold(7'h06, 10);
    chk("ena_late_digit", 64'(bus_a.digit_out), 4);
    hold(7'h6D, 10);
    chk("ena_next_digit", 64'(bus_a.digit_out), 5);

    // reset in the middle of filtering
    hold(7'h7C, 2);
    step(7'h7C, 1'b1, 1'b0, 1'b1);
    chk_zero("midreset");
    hold(7'h7C, 4);
    chk("midreset_wait", 64'(bus_a.digit_valid), 0);
    hold(7'h7C, 1);
    chk("midreset_digit", 64'(bus_a.digit_out), 6);
    chk("midreset_dv", 64'(bus_a.digit_valid), 1);

    // randomized segments
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      len = $urandom_range(4, 25);
      if (r <= 5) pat = seg_tab[(int'(m_digit) + 1) % 10];
      else if (r == 6) pat = seg_tab[$urandom_range(0, 9)];
      else if (r == 7) begin
        do pat = 7'($urandom_range(1, 127)); while (lookup(pat, dd));
      end else if (r == 8) pat = 7'h00;
      else begin
        pat = seg_tab[$urandom_range(0, 9)];
        len = $urandom_range(1, 3);
      end
      e = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < len; i++)
        step(pat, e, ($urandom_range(0, 15) == 0), 1'b0);
    end

    hold(7'h00, 10);
    chk("final_errcnt", 64'(bus_a.err_count), 64'(m_err));
    chk("final_digit", 64'(bus_b.digit_out), 64'(m_digit));
    chk("qa_drained", 64'(qa.size()), 0);
    chk("qb_drained", 64'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
